if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter IMEM_BYTES, default 4096, meaning the legal fetch window size starting at RESET_PC.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port stall_D  input  1  hazard unit holds the D stage; IF/ID register keeps its value.
REQ-006 SHALL have port PCSrc  input  1  the branch or jump in D is taken.
REQ-007 SHALL have port NPC_D  input  32  redirect target from D.
REQ-008 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-009 SHALL have port imem_addr  output  32  word-aligned fetch address (PC_F).
REQ-010 SHALL have port imem_ack  input  1  imem_rdata is valid this cycle for the outstanding request.
REQ-011 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-012 SHALL have ports Instr_D, PC4_D, PC8_D  output  32 each  the IF/ID register contents.
REQ-013 SHALL have port valid_D  output  1  Instr_D is a real fetched word (0 = bubble).
REQ-014 SHALL have port exc_adel_D  output  1  the fetch that produced Instr_D had an address error.

Function
REQ-015 SHALL run a three-state FSM: IDLE, FETCH, FULL.
- IDLE: one cycle after reset release -> FETCH.
- FETCH: imem_req=1, imem_addr=PC_F.
- FULL: fetched word held in the skid buffer, imem_req=0.
REQ-016 In FETCH with imem_ack=1 and stall_D=0: imem_rdata SHALL load into IF/ID the same edge (Instr_D, PC4_D=PC_F+4, PC8_D=PC_F+8, valid_D=1), and the FSM SHALL stay in FETCH with PC_F advanced.
REQ-017 In FETCH with imem_ack=1 and stall_D=1: the word SHALL be captured in the skid buffer, and the FSM SHALL go to FULL.
REQ-018 In FULL with stall_D=0: the buffered word SHALL load into IF/ID, and the FSM SHALL go to FETCH with PC_F advanced.
REQ-019 In FETCH with imem_ack=0 and stall_D=0: IF/ID SHALL load a bubble (Instr_D=0, valid_D=0, PC fields unchanged).
REQ-020 With stall_D=1: IF/ID SHALL hold all fields unchanged regardless of FSM state.
REQ-021 PCSrc SHALL be honoured only when valid_D=1 and stall_D=0; it is ignored otherwise.
REQ-022 Delay slot: the word fetched at PC4_D SHALL still be delivered; the PC following it SHALL be NPC_D.
REQ-023 PCSrc accepted while the delay-slot word is already handed over the same edge: PC_F SHALL become NPC_D directly.
REQ-024 PCSrc accepted while the delay-slot word is not yet handed over: NPC_D SHALL be latched into redirect_pc with redir_pend=1 and applied when that word hands over; redir_pend then clears.
REQ-025 PC_F SHALL advance by exactly +4 modulo 2^32 when there is no redirect; wrap to 0 is permitted.
REQ-026 imem_addr[1:0] SHALL always be 2'b00.

Reset
REQ-027 While reset=0: PC_F=RESET_PC, FSM=IDLE, imem_req=0, Instr_D=0, PC4_D=0, PC8_D=0, valid_D=0, exc_adel_D=0, redir_pend=0, skid buffer empty.
REQ-028 Reset asserted mid-request SHALL abandon the request; an imem_ack arriving during or after reset SHALL be ignored until FETCH is re-entered.

Configuration
REQ-029 Macro IF_ADEL_CHECK_EN SHALL be defined to compile in the address check.
- Defined: a PC_F outside [RESET_PC, RESET_PC+IMEM_BYTES) SHALL issue no imem_req. It SHALL deliver Instr_D=0, valid_D=1, exc_adel_D=1 as if acked that cycle.
- Undefined: exc_adel_D SHALL be tied 0 and all addresses fetched.

Structure
REQ-030 FSM state encoding, RESET_PC default and the NOP constant SHALL live in the shared package pipe_pkg.
REQ-031 The IF/ID register with hold/bubble load SHALL be one sub-module, if_id_reg; PC/FSM/redirect logic stays in if_stage.

Verification
REQ-032 Reset release with imem_ack tied 1 -> imem_addr sequence 0x3000, 0x3004, 0x3008; valid_D first 1 two cycles after release.
REQ-033 imem_ack delayed 3 cycles at 0x3004 -> three bubbles (valid_D=0, Instr_D=0), then Instr_D=word, PC4_D=0x3008.
REQ-034 stall_D=1 for 2 cycles while ack arrives -> IF/ID unchanged, FSM=FULL, imem_req=0; buffered word appears the cycle after stall_D drops.
REQ-035 PCSrc=1, NPC_D=0x3100 with the delay-slot ack 2 cycles late -> delay-slot word delivered, next imem_addr=0x3100.
REQ-036 With IF_ADEL_CHECK_EN, redirect to 0x4000 -> no imem_req, exc_adel_D=1, Instr_D=0; without the macro, imem_addr=0x4000 is issued.
REQ-037 reset=0 while FETCH waits on ack, then late ack -> all outputs at reset values; first post-reset fetch is 0x3000.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions.
//   if_state_e  : fetch-stage FSM encoding (idle / fetching / skid buffer full)
//   PipeResetPc : default first fetch address after reset
//   Nop         : instruction word loaded into IF/ID as a bubble
//   word_align  : clears the two byte-offset bits of an address
package pipe_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StFull  = 2'd2
  } if_state_e;

  localparam logic [31:0] PipeResetPc = 32'h0000_3000;
  localparam logic [31:0] Nop         = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load / bubble / hold control.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   load_i             : capture a fetched word (instr_i, adel_i) fetched at pc_i
//   bubble_i           : load a NOP bubble; PC fields keep their value
//   neither asserted   : hold every field (stall)
//   instr_o, pc4_o, pc8_o, valid_o, adel_o : register contents
module if_id_reg
  import pipe_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        adel_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic [31:0] pc8_o,
  output logic        valid_o,
  output logic        adel_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] pc8_q, pc8_d;
  logic        valid_q, valid_d;
  logic        adel_q, adel_d;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    pc8_d   = pc8_q;
    valid_d = valid_q;
    adel_d  = adel_q;
    if (load_i) begin
      instr_d = instr_i;
      pc4_d   = pc_i + 32'd4;
      pc8_d   = pc_i + 32'd8;
      valid_d = 1'b1;
      adel_d  = adel_i;
    end else if (bubble_i) begin
      instr_d = Nop;
      valid_d = 1'b0;
      adel_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q <= Nop;
      pc4_q   <= '0;
      pc8_q   <= '0;
      valid_q <= 1'b0;
      adel_q  <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      pc8_q   <= pc8_d;
      valid_q <= valid_d;
      adel_q  <= adel_d;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign pc8_o   = pc8_q;
  assign valid_o = valid_q;
  assign adel_o  = adel_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, fetch FSM, one-entry skid buffer and delayed-branch redirect.
//   clk, reset (async, active-low)
//   stall_D, PCSrc, NPC_D      : hazard hold, taken branch/jump in D and its target
//   imem_req, imem_addr        : fetch request and word-aligned address (PC_F)
//   imem_ack, imem_rdata       : fetch response
//   Instr_D, PC4_D, PC8_D, valid_D, exc_adel_D : IF/ID register contents
// Define IF_ADEL_CHECK_EN to suppress fetches outside [RESET_PC, RESET_PC+IMEM_BYTES) and
// deliver them as address-error words instead.
module if_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = PipeResetPc,
  parameter int unsigned IMEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_D,
  input  logic        PCSrc,
  input  logic [31:0] NPC_D,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr_D,
  output logic [31:0] PC4_D,
  output logic [31:0] PC8_D,
  output logic        valid_D,
  output logic        exc_adel_D
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        skid_adel_q, skid_adel_d;

  // Address window check; out-of-window fetches behave as an immediate ack of a NOP.
  logic        in_range;
  logic        fetch_ok;
  logic        ack_eff;
  logic [31:0] rdata_eff;
  logic        adel_now;

  assign in_range = (pc_q - RESET_PC) < IMEM_BYTES;

`ifdef IF_ADEL_CHECK_EN
  assign fetch_ok  = in_range;
  assign ack_eff   = fetch_ok ? imem_ack : 1'b1;
  assign rdata_eff = fetch_ok ? imem_rdata : Nop;
  assign adel_now  = ~fetch_ok;
`else
  logic unused_in_range;
  assign unused_in_range = in_range;
  assign fetch_ok  = 1'b1;
  assign ack_eff   = imem_ack;
  assign rdata_eff = imem_rdata;
  assign adel_now  = 1'b0;
`endif

  logic in_fetch;
  logic in_full;
  logic take_fetch;
  logic take_skid;
  logic cap_skid;
  logic handover;
  logic bubble;
  logic accept_br;

  assign in_fetch   = (state_q == StFetch);
  assign in_full    = (state_q == StFull);
  assign take_fetch = in_fetch & ack_eff & ~stall_D;
  assign cap_skid   = in_fetch & ack_eff & stall_D;
  assign take_skid  = in_full & ~stall_D;
  assign handover   = take_fetch | take_skid;
  assign bubble     = in_fetch & ~ack_eff & ~stall_D;
  // A branch only counts once it has actually left D this cycle.
  assign accept_br  = valid_D & ~stall_D & PCSrc;

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: if (cap_skid) state_d = StFull;
      StFull:  if (!stall_D) state_d = StFetch;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    imem_req = 1'b0;
    if (in_fetch && fetch_ok) begin
      imem_req = 1'b1;
    end
  end

  assign imem_addr = pc_q;

  // PC, redirect and skid buffer. PC_F only moves when its word hands over to D, so the
  // word at PC_F is always the delay slot of a branch being accepted in D.
  always_comb begin
    pc_d          = pc_q;
    redir_pend_d  = redir_pend_q;
    redirect_pc_d = redirect_pc_q;
    skid_instr_d  = skid_instr_q;
    skid_adel_d   = skid_adel_q;
    if (cap_skid) begin
      skid_instr_d = rdata_eff;
      skid_adel_d  = adel_now;
    end
    if (handover) begin
      if (redir_pend_q) begin
        pc_d         = redirect_pc_q;
        redir_pend_d = 1'b0;
      end else if (accept_br) begin
        pc_d = word_align(NPC_D);
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end else if (accept_br) begin
      // Delay slot still outstanding: remember the target until it arrives.
      redirect_pc_d = word_align(NPC_D);
      redir_pend_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= word_align(RESET_PC);
      redir_pend_q  <= 1'b0;
      redirect_pc_q <= '0;
      skid_instr_q  <= Nop;
      skid_adel_q   <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      redir_pend_q  <= redir_pend_d;
      redirect_pc_q <= redirect_pc_d;
      skid_instr_q  <= skid_instr_d;
      skid_adel_q   <= skid_adel_d;
    end
  end

  logic [31:0] ifid_instr;
  logic        ifid_adel;

  assign ifid_instr = take_skid ? skid_instr_q : rdata_eff;
  assign ifid_adel  = take_skid ? skid_adel_q : adel_now;

  if_id_reg u_if_id_reg (
    .clk_i    (clk),
    .rst_ni   (reset),
    .load_i   (handover),
    .bubble_i (bubble),
    .instr_i  (ifid_instr),
    .pc_i     (pc_q),
    .adel_i   (ifid_adel),
    .instr_o  (Instr_D),
    .pc4_o    (PC4_D),
    .pc8_o    (PC8_D),
    .valid_o  (valid_D),
    .adel_o   (exc_adel_D)
  );

endmodule
